vga_pix_feeder: RTL and testbench
=================================

Name: vga_pix_feeder

Overview:
- Buffers the RGB565 camera pixel stream in a synchronous FIFO and supplies `pix_data` to the VGA timing controller, one pixel per request.
- Sits directly upstream of the VGA timing controller and downstream of the capture/CDC stage. Its input stream is already in the `vga_clk` domain.
- Aligns camera start-of-frame with the VGA frame start.
- Substitutes a fill colour and resynchronises on underflow or misalignment.

Parameters:
- DEPTH, 1024, FIFO entries; must be a power of two, ≥4.
- FRAME_PIX, 307200, pixels per frame (640×480); sets the width of the frame pixel counter.
- FILL_COLOR, 16'h0000, RGB565 value output when no valid camera pixel is available.

Ports:
- vga_clk  in  1  sole clock, 25 MHz.
- sys_rst  in  1  synchronous, active-high reset.
- in_valid  in  1  camera pixel valid.
- in_sof  in  1  qualifies in_data as first pixel of a camera frame.
- in_data  in  16  RGB565 camera pixel.
- in_ready  out  1  FIFO can accept; a write occurs when in_valid && in_ready.
- frame_start  in  1  one-cycle pulse at start of VGA frame; arrives before the first pix_req of that frame.
- pix_req  in  1  VGA requests one pixel; asserted one cycle before the display-valid cycle.
- pix_data  out  16  pixel for the display-valid cycle.
- fill_level  out  clog2(DEPTH)+1  current FIFO occupancy.
- underflow  out  1  one-cycle pulse: pix_req in STREAM with FIFO empty.
- sync_err  out  1  one-cycle pulse: SOF misalignment or premature frame_start.
- locked  out  1  high while in ARMED or STREAM.

Behaviour:
- Reset (sys_rst=1 at posedge):
  - FIFO flushed; state HUNT; pixel counter 0.
  - pix_data=0, underflow=0, sync_err=0, locked=0, fill_level=0.
  - in_ready=0 while sys_rst is high.
  - Reset mid-frame discards all buffered data.
- FIFO:
  - Each entry is {sof, data}, 17 bits. First-word-fall-through: head entry visible combinationally.
  - in_ready = !full && !sys_rst.
  - Simultaneous push and pop is legal when not full: fill_level is unchanged.
  - No write when full; upstream must hold.
  - Pointers wrap modulo DEPTH; full/empty use an extra MSB.
- pix_data:
  - Registered, latency 1: captured at the posedge where pix_req=1, valid the following cycle.
  - Holds its value on cycles without pix_req.
  - Any request not served from the FIFO returns FILL_COLOR.
- State HUNT:
  - Pops one entry per cycle while head.sof=0 and not empty.
  - Head with sof=1 → ARMED (not popped).
  - pix_req returns FILL_COLOR.
- State ARMED:
  - No pops; pix_req returns FILL_COLOR.
  - On frame_start → STREAM, pixel counter=0.
- State STREAM, on pix_req:
  - Empty → FILL_COLOR, underflow pulse → HUNT.
  - Head.sof=1 and counter≠0 (early SOF) → FILL_COLOR, no pop, sync_err pulse → ARMED.
  - Otherwise pop, pix_data<=head.data, counter+1.
  - Pop when counter==FRAME_PIX-1 → HUNT, counter cleared.
- frame_start in STREAM with counter≠0 → sync_err pulse → HUNT.
  - frame_start in the same cycle as pix_req: frame_start has priority; the request is served FILL_COLOR.
- frame_start in HUNT is ignored.
- underflow and sync_err never assert in the same cycle. Early-SOF takes precedence only when the FIFO is non-empty.

Decomposition:
- Package vga_pkg holds:
  - RGB565 width (16) and H_VALID=640 / V_VALID=480 constants.
  - FRAME_PIX derived from H_VALID and V_VALID.
  - Default FILL_COLOR.
  - State enum: HUNT, ARMED, STREAM.
- Sub-module: sync_fifo_fwft, a single-clock show-ahead FIFO parameterised by width and depth, outputting full, empty and level.
- vga_pix_feeder holds the FSM, pixel counter and output register.

Test Plan:
(Use DEPTH=16, FRAME_PIX=8, FILL_COLOR=16'hF800.)
- Normal lock:
  - Push 8 pixels 16'h0001..16'h0008 with sof on the first → ARMED, locked=1.
  - frame_start, then 8 pix_req → pix_data 0001..0008, each one cycle after its request; state ends in HUNT.
- Leading garbage: push 3 entries with sof=0, then a frame → HUNT discards 3 entries in 3 cycles; the frame then streams correctly.
- Underflow:
  - Push only 5 pixels of a frame, then issue 8 pix_req → 0001..0005, then the 6th request returns F800.
  - underflow pulses once; the remaining requests return F800; state is HUNT.
- Early SOF: frame of 4 pixels followed by a new sof frame; 8 requests → 4 real pixels, then F800, sync_err pulse, ARMED; the next frame_start streams the new frame from pixel 0.
- Full/backpressure: hold in_valid with no pix_req → in_ready=0 at fill_level=16; no overwrite. One pop with in_valid=1 keeps fill_level=16 after refill.
- Reset mid-stream: assert sys_rst at pixel 3 of STREAM → next cycle pix_data=0, fill_level=0, locked=0, in_ready=0 until release.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared constants, state encoding and FIFO entry layout for the VGA pixel feeder.
package vga_pkg;
  localparam int RGB_W         = 16;
  localparam int H_VALID       = 640;
  localparam int V_VALID       = 480;
  localparam int FRAME_PIX_DEF = H_VALID * V_VALID;
  localparam logic [RGB_W-1:0] FILL_COLOR_DEF = 16'h0000;

  typedef enum logic [1:0] {HUNT, ARMED, STREAM} state_e;

  // One buffered camera pixel, tagged with its start-of-frame marker.
  typedef struct packed {
    logic             sof;
    logic [RGB_W-1:0] data;
  } fifo_ent_t;
endpackage

// File: rtl/sync_fifo_fwft.sv
// Single-clock show-ahead FIFO: the head entry is visible on o_rd_data while not empty.
module sync_fifo_fwft #(
  parameter  int WIDTH = 17,
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_wr_en,
  input  logic [WIDTH-1:0] i_wr_data,
  input  logic             i_rd_en,
  output logic [WIDTH-1:0] o_rd_data,
  output logic             o_full,
  output logic             o_empty,
  output logic [AW:0]      o_level
);
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr, r_rd_ptr;
  logic             w_wr, w_rd;

  // Extra pointer MSB distinguishes full from empty when the index bits match.
  assign o_empty   = (r_wr_ptr == r_rd_ptr);
  assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign o_level   = r_wr_ptr - r_rd_ptr;
  assign w_wr      = i_wr_en && !o_full;
  assign w_rd      = i_rd_en && !o_empty;
  assign o_rd_data = r_mem[r_rd_ptr[AW-1:0]];

  // Pointer update; reset flushes the FIFO by equalising the pointers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // Storage write; contents need no reset since the pointers gate visibility.
  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wr_ptr[AW-1:0]] <= i_wr_data;
  end
endmodule

// File: rtl/vga_pix_feeder.sv
// Buffers the camera pixel stream and serves one pixel per VGA request,
// aligning camera SOF with VGA frame start and filling on underflow/misalignment.
module vga_pix_feeder
  import vga_pkg::*;
#(
  parameter  int               DEPTH      = 1024,
  parameter  int               FRAME_PIX  = FRAME_PIX_DEF,
  parameter  logic [RGB_W-1:0] FILL_COLOR = FILL_COLOR_DEF,
  localparam int               LW         = $clog2(DEPTH) + 1,
  localparam int               CW         = (FRAME_PIX > 1) ? $clog2(FRAME_PIX) : 1
) (
  input  logic             vga_clk,
  input  logic             sys_rst,
  input  logic             in_valid,
  input  logic             in_sof,
  input  logic [RGB_W-1:0] in_data,
  output logic             in_ready,
  input  logic             frame_start,
  input  logic             pix_req,
  output logic [RGB_W-1:0] pix_data,
  output logic [LW-1:0]    fill_level,
  output logic             underflow,
  output logic             sync_err,
  output logic             locked
);
  state_e           r_state, w_nxt_state;
  logic [CW-1:0]    r_cnt, w_nxt_cnt;
  logic [RGB_W-1:0] r_pix_data, w_nxt_pix;
  logic             r_underflow, r_sync_err;
  logic             w_uf, w_se, w_pop, w_full, w_empty;
  logic [$bits(fifo_ent_t)-1:0] w_rd_data;
  fifo_ent_t        w_head;

  assign in_ready = !w_full && !sys_rst;
  assign w_head   = fifo_ent_t'(w_rd_data);

  sync_fifo_fwft #(.WIDTH($bits(fifo_ent_t)), .DEPTH(DEPTH)) u_fifo (
    .clk       (vga_clk),
    .rst       (sys_rst),
    .i_wr_en   (in_valid && in_ready),
    .i_wr_data ({in_sof, in_data}),
    .i_rd_en   (w_pop),
    .o_rd_data (w_rd_data),
    .o_full    (w_full),
    .o_empty   (w_empty),
    .o_level   (fill_level)
  );

  // Next-state, pop and served pixel; unserved requests get the fill colour.
  always_comb begin
    w_nxt_state = r_state;
    w_nxt_cnt   = r_cnt;
    w_nxt_pix   = pix_req ? FILL_COLOR : r_pix_data;
    w_pop       = 1'b0;
    w_uf        = 1'b0;
    w_se        = 1'b0;
    case (r_state)
      HUNT: begin
        if (!w_empty) begin
          if (w_head.sof) w_nxt_state = ARMED;
          else            w_pop       = 1'b1;
        end
      end
      ARMED: begin
        if (frame_start) begin
          w_nxt_state = STREAM;
          w_nxt_cnt   = '0;
        end
      end
      STREAM: begin
        // frame_start outranks a same-cycle request, which then gets fill.
        if (frame_start) begin
          if (r_cnt != '0) begin
            w_se        = 1'b1;
            w_nxt_state = HUNT;
            w_nxt_cnt   = '0;
          end
        end else if (pix_req) begin
          if (w_empty) begin
            w_uf        = 1'b1;
            w_nxt_state = HUNT;
            w_nxt_cnt   = '0;
          end else if (w_head.sof && r_cnt != '0) begin
            w_se        = 1'b1;
            w_nxt_state = ARMED;
            w_nxt_cnt   = '0;
          end else begin
            w_pop     = 1'b1;
            w_nxt_pix = w_head.data;
            if (r_cnt == CW'(FRAME_PIX - 1)) begin
              w_nxt_state = HUNT;
              w_nxt_cnt   = '0;
            end else begin
              w_nxt_cnt = r_cnt + 1'b1;
            end
          end
        end
      end
      default: w_nxt_state = HUNT;
    endcase
  end

  // State, counter and registered outputs.
  always_ff @(posedge vga_clk) begin
    if (sys_rst) begin
      r_state     <= HUNT;
      r_cnt       <= '0;
      r_pix_data  <= '0;
      r_underflow <= 1'b0;
      r_sync_err  <= 1'b0;
    end else begin
      r_state     <= w_nxt_state;
      r_cnt       <= w_nxt_cnt;
      r_pix_data  <= w_nxt_pix;
      r_underflow <= w_uf;
      r_sync_err  <= w_se;
    end
  end

  assign pix_data  = r_pix_data;
  assign underflow = r_underflow;
  assign sync_err  = r_sync_err;
  assign locked    = (r_state == ARMED) || (r_state == STREAM);
endmodule

// File: tb/tb_vga_pix_feeder.sv
// Scenario bench for vga_pix_feeder with a queue-based reference model.
module tb_vga_pix_feeder;
  localparam int          DEPTH = 16;
  localparam int          FP    = 8;
  localparam logic [15:0] FILL  = 16'hF800;

  logic        vga_clk = 1'b0, sys_rst = 1'b1;
  logic        in_valid = 1'b0, in_sof = 1'b0, frame_start = 1'b0, pix_req = 1'b0;
  logic [15:0] in_data = '0;
  logic        in_ready, underflow, sync_err, locked;
  logic [15:0] pix_data;
  logic [4:0]  fill_level;

  always #20 vga_clk = ~vga_clk;

  vga_pix_feeder #(.DEPTH(DEPTH), .FRAME_PIX(FP), .FILL_COLOR(FILL)) dut (
    .vga_clk(vga_clk), .sys_rst(sys_rst), .in_valid(in_valid), .in_sof(in_sof),
    .in_data(in_data), .in_ready(in_ready), .frame_start(frame_start),
    .pix_req(pix_req), .pix_data(pix_data), .fill_level(fill_level),
    .underflow(underflow), .sync_err(sync_err), .locked(locked)
  );

  // Reference model: buffered entries as a queue, mode 0=hunting 1=armed 2=streaming.
  logic [16:0] q[$];
  int          m_mode = 0, m_pos = 0;
  logic [15:0] m_pix = '0;
  bit          m_uf, m_se;
  int          n_chk = 0, n_pass = 0, cyc = 0;

  task automatic model_step();
    bit push, pop;
    push = in_valid && !sys_rst && (q.size() < DEPTH);
    pop  = 0;
    m_uf = 0;
    m_se = 0;
    if (sys_rst) begin
      q.delete(); m_mode = 0; m_pos = 0; m_pix = '0;
    end else begin
      if (pix_req) m_pix = FILL;
      if (m_mode == 0) begin
        if (q.size() > 0) begin
          if (q[0][16]) m_mode = 1;
          else          pop = 1;
        end
      end else if (m_mode == 1) begin
        if (frame_start) begin m_mode = 2; m_pos = 0; end
      end else begin
        if (frame_start) begin
          if (m_pos != 0) begin m_se = 1; m_mode = 0; m_pos = 0; end
        end else if (pix_req) begin
          if (q.size() == 0) begin
            m_uf = 1; m_mode = 0; m_pos = 0;
          end else if (q[0][16] && m_pos != 0) begin
            m_se = 1; m_mode = 1; m_pos = 0;
          end else begin
            m_pix = q[0][15:0]; pop = 1; m_pos++;
            if (m_pos == FP) begin m_mode = 0; m_pos = 0; end
          end
        end
      end
      if (pop)  void'(q.pop_front());
      if (push) q.push_back({in_sof, in_data});
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge vga_clk);
    #1;
    cyc++;
  endtask

  task automatic push_px(input bit sof, input logic [15:0] d);
    in_valid = 1; in_sof = sof; in_data = d;
    tick();
    in_valid = 0; in_sof = 0;
  endtask

  task automatic test_reset();
    sys_rst = 1;
    tick(); tick();
    n_chk++;
    if (pix_data !== 16'h0 || fill_level !== 5'd0 || locked !== 1'b0 ||
        in_ready !== 1'b0 || underflow !== 1'b0 || sync_err !== 1'b0)
      $display("FAIL reset pix=%h fill=%0d lock=%b rdy=%b uf=%b se=%b exp 0000/0/0/0/0/0",
               pix_data, fill_level, locked, in_ready, underflow, sync_err);
    else n_pass++;
    sys_rst = 0;
    tick();
    n_chk++;
    if (in_ready !== 1'b1) $display("FAIL ready_after_reset got=%b exp=1", in_ready);
    else n_pass++;
  endtask

  task automatic test_normal();
    for (int i = 0; i < 8; i++) push_px(i == 0, 16'(i + 1));
    tick();
    n_chk++;
    if (locked !== 1'b1 || fill_level !== 5'd8)
      $display("FAIL normal_armed lock=%b fill=%0d exp 1/8", locked, fill_level);
    else n_pass++;
    frame_start = 1; tick(); frame_start = 0;
    pix_req = 1;
    for (int i = 0; i < 8; i++) begin
      tick();
      n_chk++;
      if (pix_data !== 16'(i + 1)) $display("FAIL normal_pix%0d got=%h exp=%h", i, pix_data, 16'(i + 1));
      else n_pass++;
    end
    pix_req = 0; tick();
    n_chk++;
    if (locked !== 1'b0 || fill_level !== 5'd0)
      $display("FAIL normal_end lock=%b fill=%0d exp 0/0", locked, fill_level);
    else n_pass++;
  endtask

  task automatic test_garbage();
    logic [15:0] d[8];
    for (int i = 0; i < 3; i++) push_px(0, 16'($urandom));
    tick();
    n_chk++;
    if (fill_level !== 5'd0 || locked !== 1'b0)
      $display("FAIL garbage_discard fill=%0d lock=%b exp 0/0", fill_level, locked);
    else n_pass++;
    for (int i = 0; i < 8; i++) begin d[i] = 16'($urandom); push_px(i == 0, d[i]); end
    tick();
    n_chk++;
    if (fill_level !== 5'd8 || locked !== 1'b1)
      $display("FAIL garbage_armed fill=%0d lock=%b exp 8/1", fill_level, locked);
    else n_pass++;
    frame_start = 1; tick(); frame_start = 0;
    pix_req = 1;
    for (int i = 0; i < 8; i++) begin
      tick();
      n_chk++;
      if (pix_data !== d[i]) $display("FAIL garbage_pix%0d got=%h exp=%h", i, pix_data, d[i]);
      else n_pass++;
    end
    pix_req = 0; tick();
  endtask

  task automatic test_underflow();
    int npulse = 0;
    logic [15:0] e;
    for (int i = 0; i < 5; i++) push_px(i == 0, 16'(i + 1));
    tick();
    frame_start = 1; tick(); frame_start = 0;
    pix_req = 1;
    for (int i = 0; i < 8; i++) begin
      tick();
      e = (i < 5) ? 16'(i + 1) : FILL;
      n_chk++;
      if (pix_data !== e || underflow !== (i == 5))
        $display("FAIL underflow_req%0d pix=%h uf=%b exp %h/%b", i, pix_data, underflow, e, i == 5);
      else n_pass++;
      if (underflow === 1'b1) npulse++;
    end
    pix_req = 0; tick();
    n_chk++;
    if (npulse != 1 || locked !== 1'b0)
      $display("FAIL underflow_end pulses=%0d lock=%b exp 1/0", npulse, locked);
    else n_pass++;
  endtask

  task automatic test_early_sof();
    logic [15:0] e;
    for (int i = 0; i < 4; i++) push_px(i == 0, 16'(16'h0011 + i));
    for (int i = 0; i < 8; i++) push_px(i == 0, 16'(16'h0021 + i));
    frame_start = 1; tick(); frame_start = 0;
    pix_req = 1;
    for (int i = 0; i < 8; i++) begin
      tick();
      e = (i < 4) ? 16'(16'h0011 + i) : FILL;
      n_chk++;
      if (pix_data !== e || sync_err !== (i == 4) || underflow !== 1'b0)
        $display("FAIL early_sof_req%0d pix=%h se=%b uf=%b exp %h/%b/0", i, pix_data, sync_err, underflow, e, i == 4);
      else n_pass++;
    end
    pix_req = 0; tick();
    n_chk++;
    if (locked !== 1'b1 || fill_level !== 5'd8)
      $display("FAIL early_sof_armed lock=%b fill=%0d exp 1/8", locked, fill_level);
    else n_pass++;
    frame_start = 1; tick(); frame_start = 0;
    pix_req = 1;
    for (int i = 0; i < 8; i++) begin
      tick();
      n_chk++;
      if (pix_data !== 16'(16'h0021 + i))
        $display("FAIL early_sof_new%0d got=%h exp=%h", i, pix_data, 16'(16'h0021 + i));
      else n_pass++;
    end
    pix_req = 0; tick();
  endtask

  task automatic test_full();
    in_valid = 1;
    for (int k = 0; k < 20; k++) begin
      in_sof = (k == 0); in_data = 16'(16'hA000 + k);
      tick();
      n_chk++;
      if (in_ready !== (q.size() < DEPTH) || fill_level !== 5'(q.size()))
        $display("FAIL full_fill%0d rdy=%b fill=%0d exp %b/%0d", k, in_ready, fill_level, q.size() < DEPTH, q.size());
      else n_pass++;
    end
    in_sof = 0;
    n_chk++;
    if (fill_level !== 5'd16 || in_ready !== 1'b0)
      $display("FAIL full_level fill=%0d rdy=%b exp 16/0", fill_level, in_ready);
    else n_pass++;
    frame_start = 1; tick(); frame_start = 0;
    pix_req = 1; tick(); pix_req = 0;
    n_chk++;
    if (pix_data !== 16'hA000 || fill_level !== 5'd15)
      $display("FAIL full_pop pix=%h fill=%0d exp a000/15", pix_data, fill_level);
    else n_pass++;
    tick();
    n_chk++;
    if (fill_level !== 5'd16) $display("FAIL full_refill got=%0d exp=16", fill_level);
    else n_pass++;
    in_valid = 0; pix_req = 1;
    for (int i = 1; i < 8; i++) begin
      tick();
      n_chk++;
      if (pix_data !== 16'(16'hA000 + i)) $display("FAIL full_pix%0d got=%h exp=%h", i, pix_data, 16'(16'hA000 + i));
      else n_pass++;
    end
    pix_req = 0;
    for (int i = 0; i < 12; i++) tick();
    n_chk++;
    if (fill_level !== 5'd0 || locked !== 1'b0)
      $display("FAIL full_drain fill=%0d lock=%b exp 0/0", fill_level, locked);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 8; i++) push_px(i == 0, 16'(16'h0031 + i));
    frame_start = 1; tick(); frame_start = 0;
    pix_req = 1;
    for (int i = 0; i < 3; i++) tick();
    n_chk++;
    if (pix_data !== 16'h0033) $display("FAIL rstmid_pre got=%h exp=0033", pix_data);
    else n_pass++;
    sys_rst = 1; tick(); pix_req = 0;
    n_chk++;
    if (pix_data !== 16'h0 || fill_level !== 5'd0 || locked !== 1'b0 || in_ready !== 1'b0)
      $display("FAIL rstmid pix=%h fill=%0d lock=%b rdy=%b exp 0000/0/0/0", pix_data, fill_level, locked, in_ready);
    else n_pass++;
    tick();
    n_chk++;
    if (in_ready !== 1'b0) $display("FAIL rstmid_hold rdy=%b exp=0", in_ready);
    else n_pass++;
    sys_rst = 0; tick();
    n_chk++;
    if (in_ready !== 1'b1 || fill_level !== 5'd0)
      $display("FAIL rstmid_release rdy=%b fill=%0d exp 1/0", in_ready, fill_level);
    else n_pass++;
  endtask

  task automatic test_random();
    for (int c = 0; c < 3000; c++) begin
      sys_rst     = ($urandom_range(0, 399) == 0);
      in_valid    = $urandom_range(0, 1);
      in_sof      = ($urandom_range(0, 7) == 0);
      in_data     = 16'($urandom);
      pix_req     = ($urandom_range(0, 9) < 6);
      frame_start = ($urandom_range(0, 29) == 0);
      tick();
      n_chk++;
      if (pix_data !== m_pix || fill_level !== 5'(q.size()) || locked !== (m_mode != 0) ||
          underflow !== m_uf || sync_err !== m_se || in_ready !== (!sys_rst && q.size() < DEPTH))
        $display("FAIL random cyc=%0d pix=%h fill=%0d lock=%b uf=%b se=%b rdy=%b exp %h/%0d/%b/%b/%b/%b",
                 cyc, pix_data, fill_level, locked, underflow, sync_err, in_ready,
                 m_pix, q.size(), m_mode != 0, m_uf, m_se, !sys_rst && q.size() < DEPTH);
      else n_pass++;
    end
    sys_rst = 0; in_valid = 0; pix_req = 0; frame_start = 0;
  endtask

  initial begin
    test_reset();
    test_normal();
    test_garbage();
    test_underflow();
    test_early_sof();
    test_full();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
